floppy_seek_ctrl: RTL and testbench

Seek sequencer for the 8-inch floppy track path. It accepts seek and recalibrate commands for drive 0 or 1 and emits timed `step`/`dir` pulses on the same lines the track counter consumes. It keeps a per-drive track register and reports completion, error and the current track. It sits between the host command logic and the drive/track-counter interface, on the 10 MHz system clock.

---
 rtl/floppy_seek_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_floppy_seek_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/floppy_seek_ctrl.sv
// Seek/recalibrate sequencer for the 8-inch floppy track path: issues timed step/dir
// pulses, keeps a track register and calibration flag per drive, reports done/err.
module floppy_seek_ctrl #(
    parameter int unsigned STEP_PULSE_CYC = 10,
    parameter int unsigned STEP_RATE_CYC  = 80000,
    parameter int unsigned SETTLE_CYC     = 100000,
    parameter int unsigned MAX_TRACK      = 76,
    parameter int unsigned RECAL_LIMIT    = 80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_recal,
    input  logic [6:0] cmd_track,
    input  logic       cmd_drive,
    output logic       step,
    output logic       dir,
    output logic       drivenum,
    input  logic       zero_track,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [6:0] cur_track
);

    localparam int unsigned GapCyc = STEP_RATE_CYC - STEP_PULSE_CYC;
    localparam int unsigned MaxCyc = (STEP_RATE_CYC > SETTLE_CYC) ? STEP_RATE_CYC : SETTLE_CYC;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);
    localparam int unsigned StepW  = $clog2(RECAL_LIMIT + 1);

    localparam logic [CntW-1:0]  PulseLast  = CntW'(STEP_PULSE_CYC - 1);
    localparam logic [CntW-1:0]  GapLast    = CntW'(GapCyc - 1);
    localparam logic [CntW-1:0]  SettleLast = CntW'(SETTLE_CYC - 1);
    localparam logic [StepW-1:0] StepLimit  = StepW'(RECAL_LIMIT);
    localparam logic [6:0]       MaxTrack   = 7'(MAX_TRACK);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPulse,
        StGap,
        StSettle,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [StepW-1:0] steps_q, steps_d;
    logic             drive_q, drive_d;
    logic             recal_q, recal_d;
    logic [6:0]       target_q, target_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;
    logic [1:0][6:0]  track_q, track_d;
    logic [1:0]       cal_q, cal_d;
    logic             zt_meta_q, zt_sync_q;

    logic [6:0] cur;
    logic [6:0] track_next;
    logic [6:0] track_after;
    logic       issue;

    assign cur = track_q[drive_q];
    // Outward steps saturate at 0: an uncalibrated register can sit at 0 off track 0.
    assign track_next  = dir_q ? (cur + 7'd1) : ((cur == 7'd0) ? 7'd0 : (cur - 7'd1));
    assign track_after = (cnt_q == '0) ? track_next : cur;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        steps_d  = steps_q;
        drive_d  = drive_q;
        recal_d  = recal_q;
        target_d = target_q;
        dir_d    = dir_q;
        err_d    = err_q;
        track_d  = track_q;
        cal_d    = cal_q;
        issue    = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (cmd_valid) begin
                    drive_d  = cmd_drive;
                    recal_d  = cmd_recal;
                    target_d = cmd_track;
                    err_d    = 1'b0;
                    steps_d  = '0;
                    if (cmd_recal) begin
                        dir_d   = 1'b0;
                        state_d = StSetup;
                    end else if ((cmd_track > MaxTrack) || !cal_q[cmd_drive]) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else if (cmd_track == track_q[cmd_drive]) begin
                        state_d = StDone;
                    end else begin
                        dir_d   = (cmd_track > track_q[cmd_drive]);
                        state_d = StSetup;
                    end
                end
            end
            StSetup: begin
                issue = (cnt_q == PulseLast);
            end
            StPulse: begin
                if (cnt_q == '0) begin
                    track_d[drive_q] = track_next;
                    if (recal_q) begin
                        steps_d = steps_q + 1'b1;
                    end
                end
                if (cnt_q == PulseLast) begin
                    cnt_d   = '0;
                    state_d = (!recal_q && (track_after == target_q)) ? StSettle : StGap;
                end
            end
            StGap: begin
                issue = (cnt_q == GapLast);
            end
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Decision taken just before each potential step pulse.
        if (issue) begin
            cnt_d = '0;
            if (recal_q && zt_sync_q) begin
                track_d[drive_q] = 7'd0;
                cal_d[drive_q]   = 1'b1;
                state_d          = (steps_q != '0) ? StSettle : StDone;
            end else if (recal_q && (steps_q == StepLimit)) begin
                cal_d[drive_q] = 1'b0;
                err_d          = 1'b1;
                state_d        = StDone;
            end else begin
                state_d = StPulse;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            steps_q   <= '0;
            drive_q   <= 1'b0;
            recal_q   <= 1'b0;
            target_q  <= 7'd0;
            dir_q     <= 1'b0;
            err_q     <= 1'b0;
            track_q   <= '0;
            cal_q     <= 2'b00;
            zt_meta_q <= 1'b0;
            zt_sync_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            steps_q   <= steps_d;
            drive_q   <= drive_d;
            recal_q   <= recal_d;
            target_q  <= target_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
            track_q   <= track_d;
            cal_q     <= cal_d;
            zt_meta_q <= zero_track;
            zt_sync_q <= zt_meta_q;
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = ~cmd_ready;
    assign step      = (state_q == StPulse);
    assign done      = (state_q == StDone);
    assign dir       = dir_q;
    assign drivenum  = drive_q;
    assign err       = err_q;
    assign cur_track = cur;

endmodule

// File: tb/tb_floppy_seek_ctrl.sv
// Randomized bench for floppy_seek_ctrl: per-command expectations come from a
// per-drive track/calibration model and the pulse/settle timing rules.
module tb_floppy_seek_ctrl;

    localparam int P  = 2;
    localparam int R  = 8;
    localparam int S  = 5;
    localparam int MT = 76;
    localparam int RL = 80;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_recal = 1'b0;
    logic [6:0] cmd_track = 7'd0;
    logic       cmd_drive = 1'b0;
    logic       zero_track = 1'b0;
    logic       cmd_ready, step, dir, drivenum, busy, done, err;
    logic [6:0] cur_track;

    int n_checks = 0;
    int n_errors = 0;
    int mdl_track [2];
    bit mdl_cal   [2];

    always #5 clk = ~clk;

    floppy_seek_ctrl #(
        .STEP_PULSE_CYC (P),
        .STEP_RATE_CYC  (R),
        .SETTLE_CYC     (S),
        .MAX_TRACK      (MT),
        .RECAL_LIMIT    (RL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_recal  (cmd_recal),
        .cmd_track  (cmd_track),
        .cmd_drive  (cmd_drive),
        .step       (step),
        .dir        (dir),
        .drivenum   (drivenum),
        .zero_track (zero_track),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cur_track  (cur_track)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_step"}, int'(step), 0);
        check({tag, "_dir"}, int'(dir), 0);
        check({tag, "_drivenum"}, int'(drivenum), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_ready"}, int'(cmd_ready), 1);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_track"}, int'(cur_track), 0);
    endtask

    // zt_after: recal only; 0 = sensor already high, k = raise after k-th step, -1 = never.
    task automatic run_cmd(input bit recal, input int trk, input bit drv, input int zt_after,
                           input bit spam);
        int exp_n, exp_err, exp_track, exp_dir, exp_done;
        bit exp_cal;
        int n, c, rise_c, last_hi, done_c;
        bit prev;

        exp_n     = 0;
        exp_err   = 0;
        exp_dir   = 0;
        exp_track = mdl_track[drv];
        exp_cal   = mdl_cal[drv];
        if (!recal) begin
            if (trk > MT || !mdl_cal[drv]) begin
                exp_err = 1;
            end else if (trk != mdl_track[drv]) begin
                exp_n     = (trk > mdl_track[drv]) ? trk - mdl_track[drv] : mdl_track[drv] - trk;
                exp_dir   = (trk > mdl_track[drv]) ? 1 : 0;
                exp_track = trk;
            end
        end else if (zt_after < 0) begin
            exp_n     = RL;
            exp_err   = 1;
            exp_cal   = 1'b0;
            exp_track = (mdl_track[drv] > RL) ? mdl_track[drv] - RL : 0;
        end else begin
            exp_n     = zt_after;
            exp_track = 0;
            exp_cal   = 1'b1;
        end

        zero_track = recal && (zt_after == 0);
        repeat (3) @(negedge clk);
        check("ready_before", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_recal = recal;
        cmd_track = 7'(trk);
        cmd_drive = drv;

        c = 0; n = 0; prev = 1'b0; rise_c = 0; last_hi = 0; done_c = -1;
        while (done_c < 0 && c < 1000) begin
            @(negedge clk);
            c++;
            if (spam) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_recal = 1'($urandom_range(0, 1));
                cmd_track = 7'($urandom_range(0, 127));
                cmd_drive = 1'($urandom_range(0, 1));
            end else begin
                cmd_valid = 1'b0;
            end
            if (c == 1) check("busy_after_accept", int'(busy), 1);
            if (step && !prev) begin
                check("rise_time", c, 1 + P + n * R);
                check("dir", int'(dir), exp_dir);
                rise_c = c;
                n++;
            end
            if (!step && prev) begin
                check("width", c - rise_c, P);
                if (recal && n == zt_after) zero_track = 1'b1;
            end
            if (step) last_hi = c;
            prev = step;
            if (done) begin
                done_c    = c;
                cmd_valid = 1'b0;
            end
        end

        if (exp_n == 0)   exp_done = recal ? 1 + P : 1;
        else if (!recal)  exp_done = last_hi + S + 1;
        else if (exp_err) exp_done = last_hi + (R - P) + 1;
        else              exp_done = last_hi + (R - P) + S + 1;

        if (done_c < 0) begin
            check("done_timeout", 0, 1);
        end else begin
            check("done_time", done_c, exp_done);
        end
        check("pulses", n, exp_n);
        check("err", int'(err), exp_err);
        check("track", int'(cur_track), exp_track);
        check("drivenum", int'(drivenum), int'(drv));

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_second_done", int'(done), 0);
            check("ready_after", int'(cmd_ready), 1);
            check("err_held", int'(err), exp_err);
        end

        mdl_track[drv] = exp_track;
        mdl_cal[drv]   = exp_cal;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        int rises, c;
        bit prev, r, drv;
        int trk, zt;

        mdl_track[0] = 0; mdl_track[1] = 0;
        mdl_cal[0]   = 1'b0; mdl_cal[1] = 1'b0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;
        @(negedge clk);
        check("por_ready", int'(cmd_ready), 1);

        run_cmd(1'b0, 10, 1'b1, 0, 1'b0);
        run_cmd(1'b0, 77, 1'b0, 0, 1'b0);
        run_cmd(1'b1, 0, 1'b0, 3, 1'b0);
        run_cmd(1'b0, 5, 1'b0, 0, 1'b0);
        run_cmd(1'b0, 2, 1'b0, 0, 1'b0);
        run_cmd(1'b0, 77, 1'b0, 0, 1'b0);
        run_cmd(1'b0, 2, 1'b0, 0, 1'b1);
        run_cmd(1'b1, 0, 1'b1, -1, 1'b0);
        run_cmd(1'b0, 3, 1'b1, 0, 1'b0);
        run_cmd(1'b1, 0, 1'b1, 0, 1'b0);
        run_cmd(1'b0, MT, 1'b1, 0, 1'b1);

        for (int i = 0; i < 16; i++) begin
            r   = ($urandom_range(0, 3) == 0);
            drv = 1'($urandom_range(0, 1));
            zt  = 0;
            trk = 0;
            if (r) zt = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 6));
            else trk = ($urandom_range(0, 7) == 0) ? int'($urandom_range(77, 127))
                                                   : int'($urandom_range(0, MT));
            run_cmd(r, trk, drv, zt, 1'($urandom_range(0, 1)));
        end

        // Reset landing in the first cycle of a step pulse.
        run_cmd(1'b1, 0, 1'b0, 0, 1'b0);
        zero_track = 1'b0;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b1; cmd_recal = 1'b0; cmd_drive = 1'b0; cmd_track = 7'd40;
        rises = 0; c = 0; prev = 1'b0;
        while (rises < 3 && c < 200) begin
            @(negedge clk);
            c++;
            cmd_valid = 1'b0;
            if (step && !prev) rises++;
            prev = step;
        end
        check("reset_pulse_seen", rises, 3);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_step_drop", int'(step), 0);
        repeat (2) @(negedge clk);
        check_reset("midrst");
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready", int'(cmd_ready), 1);
        mdl_track[0] = 0; mdl_track[1] = 0;
        mdl_cal[0]   = 1'b0; mdl_cal[1] = 1'b0;
        run_cmd(1'b0, 4, 1'b0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
